// File: rtl/pe_ctrl_pkg.sv
// Shared types and elaboration helpers for the PE-array controller.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_FILT  = 3'd1,
    LD_IFMAP = 3'd2,
    CONV     = 3'd3,
    DONE     = 3'd4
  } pe_ctrl_state_e;

  localparam int unsigned PERF_W = 16;

  // One diagonal per distinct (row + col) sum across the array.
  function automatic int unsigned num_diags(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

  // Counter width for a 0..bound-1 range; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned bound);
    return (bound <= 1) ? 1 : $clog2(bound);
  endfunction

endpackage

// File: rtl/pe_ctrl_beat_cnt.sv
// Beat counter 0..MAX-1 that advances on en, wraps after the last beat and clears synchronously.
module pe_ctrl_beat_cnt
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  output logic [cnt_w(MAX)-1:0]    cnt,
  output logic                     last_c
);

  localparam int unsigned W = cnt_w(MAX);

  assign last_c = (cnt == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pe_array_controller.sv
// Sequencer for the PE-array control bundle: one filter load, then cfg_num_windows ifmap/conv passes.
// Optional stall counter port perf_stall_cnt enabled by defining PE_CTRL_PERF_EN.
module pe_array_controller
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = 3,
  parameter int unsigned NUM_COLS    = 3,
  parameter int unsigned CONV_CYCLES = 4,
  parameter int unsigned WIN_W       = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [WIN_W-1:0]                          cfg_num_windows,
  input  logic                                      filter_valid,
  output logic                                      filter_ready,
  input  logic                                      ifmap_valid,
  output logic                                      ifmap_ready,
  output logic [NUM_ROWS-1:0]                       read_new_filter_val,
  output logic [num_diags(NUM_ROWS, NUM_COLS)-1:0]  read_new_ifmap_val,
  output logic                                      start_conv,
  output logic                                      busy,
  output logic                                      done
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]                         perf_stall_cnt
`endif
);

  localparam int unsigned NUM_DIAGS = num_diags(NUM_ROWS, NUM_COLS);
  localparam int unsigned ROW_W     = cnt_w(NUM_ROWS);
  localparam int unsigned DIAG_W    = cnt_w(NUM_DIAGS);
  localparam int unsigned CONV_W    = cnt_w(CONV_CYCLES);

  pe_ctrl_state_e state, next_state;

  logic [WIN_W-1:0]     win_left, win_left_d;
  logic [NUM_ROWS-1:0]  filt_strb_d;
  logic [NUM_DIAGS-1:0] ifmap_strb_d;
  logic                 start_conv_d;
  logic                 filter_ready_d, ifmap_ready_d, busy_d, done_d;

  logic [ROW_W-1:0]     row_cnt;
  logic [DIAG_W-1:0]    diag_cnt;
  logic [CONV_W-1:0]    conv_cnt;
  logic                 row_last_c, diag_last_c, conv_last_c;
  logic                 start_acc_c, filt_acc_c, ifmap_acc_c;

  assign start_acc_c = (state == IDLE) && start;
  assign filt_acc_c  = (state == LD_FILT) && filter_valid && filter_ready;
  assign ifmap_acc_c = (state == LD_IFMAP) && ifmap_valid && ifmap_ready;

  pe_ctrl_beat_cnt #(.MAX(NUM_ROWS)) u_row_cnt (
    .clk(clk), .rst_n(rst_n), .en(filt_acc_c), .clear(start_acc_c),
    .cnt(row_cnt), .last_c(row_last_c)
  );

  pe_ctrl_beat_cnt #(.MAX(NUM_DIAGS)) u_diag_cnt (
    .clk(clk), .rst_n(rst_n), .en(ifmap_acc_c), .clear(start_acc_c),
    .cnt(diag_cnt), .last_c(diag_last_c)
  );

  // Counts asserted start_conv cycles; the first CONV cycle lets the last ifmap strobe drain.
  pe_ctrl_beat_cnt #(.MAX(CONV_CYCLES)) u_conv_cnt (
    .clk(clk), .rst_n(rst_n), .en(start_conv), .clear(start_acc_c),
    .cnt(conv_cnt), .last_c(conv_last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      win_left            <= '0;
      filter_ready        <= 1'b0;
      ifmap_ready         <= 1'b0;
      read_new_filter_val <= '0;
      read_new_ifmap_val  <= '0;
      start_conv          <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state               <= next_state;
      win_left            <= win_left_d;
      filter_ready        <= filter_ready_d;
      ifmap_ready         <= ifmap_ready_d;
      read_new_filter_val <= filt_strb_d;
      read_new_ifmap_val  <= ifmap_strb_d;
      start_conv          <= start_conv_d;
      busy                <= busy_d;
      done                <= done_d;
    end
  end

  always_comb begin
    next_state   = state;
    win_left_d   = win_left;
    filt_strb_d  = '0;
    ifmap_strb_d = '0;
    start_conv_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = LD_FILT;
          win_left_d = (cfg_num_windows == '0) ? WIN_W'(1) : cfg_num_windows;
        end
      end
      LD_FILT: begin
        if (filt_acc_c) begin
          filt_strb_d = NUM_ROWS'(1) << row_cnt;
          if (row_last_c) next_state = LD_IFMAP;
        end
      end
      LD_IFMAP: begin
        if (ifmap_acc_c) begin
          ifmap_strb_d = NUM_DIAGS'(1) << diag_cnt;
          if (diag_last_c) next_state = CONV;
        end
      end
      CONV: begin
        start_conv_d = 1'b1;
        if (start_conv && conv_last_c) begin
          start_conv_d = 1'b0;
          win_left_d   = win_left - WIN_W'(1);
          next_state   = (win_left == WIN_W'(1)) ? DONE : LD_IFMAP;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // Level outputs follow the state being entered so ready drops on the final accepted beat.
    filter_ready_d = (next_state == LD_FILT);
    ifmap_ready_d  = (next_state == LD_IFMAP);
    busy_d         = (next_state != IDLE);
    done_d         = (next_state == DONE);
  end

`ifdef PE_CTRL_PERF_EN
  logic stall_c;
  assign stall_c = (filter_ready && !filter_valid) || (ifmap_ready && !ifmap_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (start_acc_c) begin
      perf_stall_cnt <= '0;
    end else if (stall_c && (perf_stall_cnt != {PERF_W{1'b1}})) begin
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_controller.sv
// Bench for pe_array_controller: job table, corner sequences and random valids against an event-order model.
module tb_pe_array_controller;

  localparam int unsigned NR = 3;
  localparam int unsigned NC = 3;
  localparam int unsigned ND = NR + NC - 1;
  localparam int unsigned CC = 4;
  localparam int unsigned WW = 8;
  localparam int          BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] cfg_num_windows = '0;
  logic          filter_valid = 1'b0;
  logic          ifmap_valid = 1'b0;
  logic          filter_ready, ifmap_ready;
  logic [NR-1:0] read_new_filter_val;
  logic [ND-1:0] read_new_ifmap_val;
  logic          start_conv, busy, done;
`ifdef PE_CTRL_PERF_EN
  logic [15:0]   perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  pe_array_controller #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .CONV_CYCLES(CC), .WIN_W(WW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_num_windows(cfg_num_windows),
    .filter_valid(filter_valid),
    .filter_ready(filter_ready),
    .ifmap_valid(ifmap_valid),
    .ifmap_ready(ifmap_ready),
    .read_new_filter_val(read_new_filter_val),
    .read_new_ifmap_val(read_new_ifmap_val),
    .start_conv(start_conv),
    .busy(busy),
    .done(done)
`ifdef PE_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int n_filt, n_ifmap, n_conv, n_done;
  bit prev_f, prev_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_bit(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event codes: 100+row filter strobe, 200+diag ifmap strobe, 300 conv cycle, 400 done.
  always @(negedge clk) begin
    int code;
    int e;
    int ones;
    if (!rst_n) begin
      prev_f = 1'b0;
      prev_i = 1'b0;
    end else begin
      ones = $countones(read_new_filter_val) + $countones(read_new_ifmap_val) + int'(start_conv);
      chk("one_active", int'(ones <= 1), 1);
      chk("filt_strobe_latency", int'(read_new_filter_val != '0), int'(prev_f));
      chk("ifmap_strobe_latency", int'(read_new_ifmap_val != '0), int'(prev_i));
      code = -1;
      if (read_new_filter_val != '0) begin
        code = 100 + low_bit(16'(read_new_filter_val));
        n_filt++;
      end else if (read_new_ifmap_val != '0) begin
        code = 200 + low_bit(16'(read_new_ifmap_val));
        n_ifmap++;
      end else if (start_conv) begin
        code = 300;
        n_conv++;
      end
      if (code != -1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("event_order", code, e);
      end
      if (done) begin
        n_done++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("event_order_done", 400, e);
      end
      prev_f = filter_ready && filter_valid;
      prev_i = ifmap_ready && ifmap_valid;
    end
  end

  // Reference: filter rows once, then per window every diagonal then CC conv cycles, then done.
  task automatic push_job(input int win);
    int wn;
    wn = (win == 0) ? 1 : win;
    for (int r = 0; r < int'(NR); r++) exp_q.push_back(100 + r);
    for (int w = 0; w < wn; w++) begin
      for (int d = 0; d < int'(ND); d++) exp_q.push_back(200 + d);
      for (int c = 0; c < int'(CC); c++) exp_q.push_back(300);
    end
    exp_q.push_back(400);
  endtask

  task automatic run_job(input int win, input int fprob, input int iprob,
                         input int stall_at, input int stall_len, input bit poke_start,
                         output int lat);
    push_job(win);
    n_filt = 0; n_ifmap = 0; n_conv = 0; n_done = 0;
    cfg_num_windows = WW'(win);
    start = 1'b1;
    filter_valid = ($urandom_range(0, 99) < fprob);
    ifmap_valid  = ($urandom_range(0, 99) < iprob);
    lat = 0;
    while (1) begin
      tick();
      lat++;
      start = 1'b0;
      if (done) break;
      if (lat >= BUDGET) begin
        chk("job_timeout", lat, -1);
        exp_q.delete();
        break;
      end
      if (poke_start && start_conv) begin
        start = 1'b1;
        cfg_num_windows = 8'd5;
      end
      filter_valid = ($urandom_range(0, 99) < fprob);
      if (lat >= stall_at && lat < stall_at + stall_len) ifmap_valid = 1'b0;
      else ifmap_valid = ($urandom_range(0, 99) < iprob);
    end
    start = poke_start;
    tick();
    start = 1'b0;
    chk("busy_after_done", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_filter_ready"}, int'(filter_ready), 0);
    chk({tag, "_ifmap_ready"}, int'(ifmap_ready), 0);
    chk({tag, "_filt_strobe"}, int'(read_new_filter_val), 0);
    chk({tag, "_ifmap_strobe"}, int'(read_new_ifmap_val), 0);
    chk({tag, "_start_conv"}, int'(start_conv), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  typedef struct {
    int win;
    int filt;
    int ifm;
    int conv;
    int dn;
    int lat;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int lat;
    int w;
    tbl[0] = '{win: 1, filt: 3, ifm: 5,  conv: 4,  dn: 1, lat: 14};
    tbl[1] = '{win: 3, filt: 3, ifm: 15, conv: 12, dn: 1, lat: 34};
    tbl[2] = '{win: 0, filt: 3, ifm: 5,  conv: 4,  dn: 1, lat: 14};
    tbl[3] = '{win: 2, filt: 3, ifm: 10, conv: 8,  dn: 1, lat: 24};

    // Reset held with start and valids asserted: nothing may move.
    start = 1'b1; cfg_num_windows = 8'd3; filter_valid = 1'b1; ifmap_valid = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("in_reset");
    start = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk_all_zero("idle");
`ifdef PE_CTRL_PERF_EN
    chk("perf_reset", int'(perf_stall_cnt), 0);
`endif

    foreach (tbl[i]) begin
      run_job(tbl[i].win, 100, 100, -1, 0, 1'b0, lat);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_filt", i), n_filt, tbl[i].filt);
      chk($sformatf("tbl%0d_ifmap", i), n_ifmap, tbl[i].ifm);
      chk($sformatf("tbl%0d_conv", i), n_conv, tbl[i].conv);
      chk($sformatf("tbl%0d_done", i), n_done, tbl[i].dn);
    end

    // ifmap_valid low for five cycles after two diagonals have been accepted.
    run_job(1, 100, 100, 6, 5, 1'b0, lat);
    chk("stall_latency", lat, 19);
    chk("stall_ifmap", n_ifmap, 5);
`ifdef PE_CTRL_PERF_EN
    chk("stall_perf", int'(perf_stall_cnt), 5);
`endif

    // start raised during CONV and during DONE must be ignored.
    run_job(1, 100, 100, -1, 0, 1'b1, lat);
    chk("poke_latency", lat, 14);
    chk("poke_done", n_done, 1);
    tick(); tick();
    chk("poke_no_restart", int'(busy), 0);

    // Reset mid-CONV aborts at once, then a fresh job runs normally.
    push_job(2);
    n_done = 0;
    cfg_num_windows = 8'd2; filter_valid = 1'b1; ifmap_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && !start_conv; k++) tick();
    chk("reach_conv", int'(start_conv), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
`ifdef PE_CTRL_PERF_EN
    chk("abort_perf", int'(perf_stall_cnt), 0);
`endif
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", int'(busy), 0);
    run_job(1, 100, 100, -1, 0, 1'b0, lat);
    chk("restart_latency", lat, 14);
    chk("restart_done", n_done, 1);

    // Random valids and window counts.
    for (int j = 0; j < 8; j++) begin
      w = int'($urandom_range(0, 3));
      run_job(w, int'($urandom_range(25, 100)), int'($urandom_range(25, 100)), -1, 0, 1'b0, lat);
      chk($sformatf("rnd%0d_done", j), n_done, 1);
      chk($sformatf("rnd%0d_filt", j), n_filt, int'(NR));
      chk($sformatf("rnd%0d_ifmap", j), n_ifmap, int'(ND) * ((w == 0) ? 1 : w));
      chk($sformatf("rnd%0d_conv", j), n_conv, int'(CC) * ((w == 0) ? 1 : w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
